// File: rtl/axi_burst_mem_slave_if.sv
// AR/R/AW/W/B channel bundle between a burst master and the memory slave.
interface axi_burst_mem_slave_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) ();
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [ID_W-1:0]   ARID;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [ID_W-1:0]   RID;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [ID_W-1:0]   AWID;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST;
    logic              BVALID;
    logic              BREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARID, RREADY,
        input  AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, BREADY,
        output ARREADY, RVALID, RDATA, RID, RRESP, RLAST,
        output AWREADY, WREADY, BVALID, BID, BRESP
    );

    modport master (
        output ARVALID, ARADDR, ARLEN, ARID, RREADY,
        output AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, BREADY,
        input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST,
        input  AWREADY, WREADY, BVALID, BID, BRESP
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave with independent read and write FSMs; first R beat one cycle after AR.
// R beats hold while RREADY=0; B holds until BREADY; out-of-range beats answer SLVERR.
module axi_burst_mem_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_burst_mem_slave_if.slave    bus
);
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        rstate_q, rstate_d;
    logic [ADDR_W-1:0] raddr_q,  raddr_d;
    logic [LEN_W-1:0]  rlen_q,   rlen_d;
    logic [LEN_W-1:0]  rcnt_q,   rcnt_d;
    logic [ID_W-1:0]   rid_q,    rid_d;

    logic [1:0]        wstate_q, wstate_d;
    logic [ADDR_W-1:0] waddr_q,  waddr_d;
    logic [LEN_W-1:0]  wlen_q,   wlen_d;
    logic [LEN_W-1:0]  wcnt_q,   wcnt_d;
    logic [ID_W-1:0]   wid_q,    wid_d;
    logic              werr_q,   werr_d;

    logic r_act, r_ok, r_last;
    logic w_beat, w_ok, w_last;

    assign r_act  = (rstate_q == R_DATA);
    assign r_ok   = ({1'b0, raddr_q} < DEPTH_L);
    assign r_last = (rcnt_q == rlen_q);
    assign w_beat = (wstate_q == W_DATA) && bus.WVALID;
    assign w_ok   = ({1'b0, waddr_q} < DEPTH_L);
    assign w_last = (wcnt_q == wlen_q);

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rid_d    = rid_q;
        case (rstate_q)
            R_IDLE: if (bus.ARVALID) begin
                rstate_d = R_DATA;
                raddr_d  = bus.ARADDR;
                rlen_d   = bus.ARLEN;
                rid_d    = bus.ARID;
                rcnt_d   = '0;
            end
            default: if (bus.RREADY) begin
                raddr_d = raddr_q + ADDR_W'(1);
                rcnt_d  = rcnt_q + LEN_W'(1);
                if (r_last) rstate_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wid_d    = wid_q;
        werr_d   = werr_q;
        case (wstate_q)
            W_IDLE: if (bus.AWVALID) begin
                wstate_d = W_DATA;
                waddr_d  = bus.AWADDR;
                wlen_d   = bus.AWLEN;
                wid_d    = bus.AWID;
                wcnt_d   = '0;
            end
            W_DATA: if (bus.WVALID) begin
                waddr_d = waddr_q + ADDR_W'(1);
                wcnt_d  = wcnt_q + LEN_W'(1);
                // burst length is owned by the slave; WLAST is only cross-checked
                if (!w_ok || (bus.WLAST != w_last)) werr_d = 1'b1;
                if (w_last) wstate_d = W_RESP;
            end
            W_RESP: if (bus.BREADY) begin
                werr_d   = 1'b0;
                wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rid_q    <= '0;
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wid_q    <= '0;
            werr_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rid_q    <= rid_d;
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wid_q    <= wid_d;
            werr_q   <= werr_d;
        end
    end

    // storage is deliberately left uninitialised across reset
    always_ff @(posedge clk) begin
        if (!rst && w_beat && w_ok) mem_q[waddr_q[IDX_W-1:0]] <= bus.WDATA;
    end

    assign bus.ARREADY = (rstate_q == R_IDLE);
    assign bus.RVALID  = r_act;
    assign bus.RDATA   = (r_act && r_ok) ? mem_q[raddr_q[IDX_W-1:0]] : '0;
    assign bus.RID     = r_act ? rid_q : '0;
    assign bus.RRESP   = (r_act && !r_ok) ? 2'b10 : 2'b00;
    assign bus.RLAST   = r_act && r_last;

    assign bus.AWREADY = (wstate_q == W_IDLE);
    assign bus.WREADY  = (wstate_q == W_DATA);
    assign bus.BVALID  = (wstate_q == W_RESP);
    assign bus.BID     = (wstate_q == W_RESP) ? wid_q : '0;
    assign bus.BRESP   = ((wstate_q == W_RESP) && werr_q) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Bench: table-driven and randomized bursts checked against a word-array memory model.
module tb_axi_burst_mem_slave;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_burst_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_burst_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ref_mem [256];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] len;
        logic [3:0] id;
        int         bad_beat;
        bit         fixed;
        logic [1:0] exp_bresp;
    } wvec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [3:0]  id;
        bit          use_pat;
        logic [31:0] pat;
        int          exp_cycles;
    } rvec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input int bad_beat, input bit fixed, output logic [1:0] got_resp);
        logic [7:0] a;
        logic [7:0] d;
        bit err;
        bit wl;
        int t;
        a = addr;
        err = 1'b0;
        bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWLEN = len; bus.AWID = id;
        t = 0;
        while (!bus.AWREADY && t < 50) begin @(negedge clk); t++; end
        check("awready", 32'(bus.AWREADY), 32'd1);
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (!fixed && $urandom_range(0, 3) == 0) begin
                bus.WVALID = 1'b0;
                @(negedge clk);
            end
            d  = fixed ? 8'(b + 1) : 8'($urandom);
            wl = (b == int'(len)) ^ (b == bad_beat);
            bus.WVALID = 1'b1; bus.WDATA = d; bus.WLAST = wl;
            t = 0;
            while (!bus.WREADY && t < 50) begin @(negedge clk); t++; end
            check("wready", 32'(bus.WREADY), 32'd1);
            if (int'(a) < DEPTH) ref_mem[a] = d;
            else err = 1'b1;
            if (wl != (b == int'(len))) err = 1'b1;
            a++;
            @(negedge clk);
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        t = 0;
        while (!bus.BVALID && t < 50) begin @(negedge clk); t++; end
        check("bvalid", 32'(bus.BVALID), 32'd1);
        check("bid", 32'(bus.BID), 32'(id));
        check("bresp", 32'(bus.BRESP), err ? 32'd2 : 32'd0);
        got_resp = bus.BRESP;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bus.BVALID), 32'd1);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("b_done", 32'(bus.BVALID), 32'd0);
        check("awready_after_b", 32'(bus.AWREADY), 32'd1);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input bit use_pat, input logic [31:0] pat, output int cycles);
        logic [7:0] a;
        bit ok;
        bit rr;
        int b;
        int t;
        bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARLEN = len; bus.ARID = id;
        t = 0;
        while (!bus.ARREADY && t < 50) begin @(negedge clk); t++; end
        check("arready", 32'(bus.ARREADY), 32'd1);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        a = addr; b = 0; cycles = 0;
        while (b <= int'(len) && cycles < 200) begin
            rr = use_pat ? ((cycles < 32) ? pat[cycles] : 1'b1) : ($urandom_range(0, 2) != 0);
            bus.RREADY = rr;
            ok = (int'(a) < DEPTH);
            check("rvalid", 32'(bus.RVALID), 32'd1);
            check("rdata", 32'(bus.RDATA), ok ? 32'(ref_mem[a]) : 32'd0);
            check("rresp", 32'(bus.RRESP), ok ? 32'd0 : 32'd2);
            check("rid", 32'(bus.RID), 32'(id));
            check("rlast", 32'(bus.RLAST), 32'(b == int'(len)));
            if (rr) begin b++; a++; end
            @(negedge clk);
            cycles++;
        end
        bus.RREADY = 1'b0;
        check("r_done", 32'(bus.RVALID), 32'd0);
        check("arready_after_r", 32'(bus.ARREADY), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wvec_t wtab[5];
        rvec_t rtab[4];
        logic [1:0] resp;
        int cyc;
        int cyc2;
        logic [7:0] old_d;
        logic [7:0] new_d;

        wtab[0] = '{8'd1,   4'd2, 4'd1, -1, 1'b1, 2'b00};
        wtab[1] = '{8'd50,  4'd3, 4'd2,  2, 1'b0, 2'b10};
        wtab[2] = '{8'd50,  4'd3, 4'd3, -1, 1'b0, 2'b00};
        wtab[3] = '{8'd253, 4'd3, 4'd4, -1, 1'b0, 2'b10};
        wtab[4] = '{8'd60,  4'd0, 4'd5,  0, 1'b0, 2'b10};
        rtab[0] = '{8'd1,   4'd2,  4'd1, 1'b1, 32'hFFFF_FFFF, 3};
        rtab[1] = '{8'd1,   4'd2,  4'd1, 1'b1, 32'h0000_0019, 5};
        rtab[2] = '{8'd255, 4'd1,  4'd7, 1'b1, 32'hFFFF_FFFF, 2};
        rtab[3] = '{8'd250, 4'd15, 4'd9, 1'b0, 32'h0,         -1};

        bus.ARVALID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARID = 0; bus.RREADY = 0;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWID = 0;
        bus.WVALID = 0; bus.WDATA = 0; bus.WLAST = 0; bus.BREADY = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_arready", 32'(bus.ARREADY), 32'd1);
        check("rst_awready", 32'(bus.AWREADY), 32'd1);
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_wready", 32'(bus.WREADY), 32'd0);
        check("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("rst_rlast", 32'(bus.RLAST), 32'd0);
        check("rst_rdata", 32'(bus.RDATA), 32'd0);
        check("rst_rresp", 32'(bus.RRESP), 32'd0);
        check("rst_bresp", 32'(bus.BRESP), 32'd0);

        // known contents everywhere so every read can be predicted
        for (int k = 0; k < 16; k++) do_write(8'(k * 16), 4'd15, 4'(k), -1, 1'b0, resp);

        foreach (wtab[i]) begin
            do_write(wtab[i].addr, wtab[i].len, wtab[i].id, wtab[i].bad_beat, wtab[i].fixed, resp);
            check("bresp_table", 32'(resp), 32'(wtab[i].exp_bresp));
        end
        check("mem1_tbl", 32'(ref_mem[1]), 32'h01);
        foreach (rtab[i]) begin
            do_read(rtab[i].addr, rtab[i].len, rtab[i].id, rtab[i].use_pat, rtab[i].pat, cyc);
            if (rtab[i].exp_cycles >= 0) check("read_cycles", 32'(cyc), 32'(rtab[i].exp_cycles));
        end

        // stalled read at the address a write commits to
        old_d = ref_mem[20];
        new_d = old_d ^ 8'hA5;
        bus.ARVALID = 1; bus.ARADDR = 8'd20; bus.ARLEN = 0; bus.ARID = 4'd3; bus.RREADY = 0;
        @(negedge clk);
        bus.ARVALID = 0;
        check("coll_rvalid", 32'(bus.RVALID), 32'd1);
        check("coll_old0", 32'(bus.RDATA), 32'(old_d));
        bus.AWVALID = 1; bus.AWADDR = 8'd20; bus.AWLEN = 0; bus.AWID = 4'd6;
        @(negedge clk);
        bus.AWVALID = 0;
        check("coll_wready", 32'(bus.WREADY), 32'd1);
        bus.WVALID = 1; bus.WDATA = new_d; bus.WLAST = 1;
        check("coll_old1", 32'(bus.RDATA), 32'(old_d));
        @(negedge clk);
        bus.WVALID = 0; bus.WLAST = 0;
        ref_mem[20] = new_d;
        check("coll_new", 32'(bus.RDATA), 32'(new_d));
        check("coll_rlast", 32'(bus.RLAST), 32'd1);
        check("coll_bvalid", 32'(bus.BVALID), 32'd1);
        check("coll_bid", 32'(bus.BID), 32'd6);
        check("coll_bresp", 32'(bus.BRESP), 32'd0);
        bus.RREADY = 1; bus.BREADY = 1;
        @(negedge clk);
        bus.RREADY = 0; bus.BREADY = 0;
        check("coll_rdone", 32'(bus.RVALID), 32'd0);
        check("coll_bdone", 32'(bus.BVALID), 32'd0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(8'($urandom), 4'($urandom), 4'($urandom),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1, 1'b0, resp);
            else
                do_read(8'($urandom), 4'($urandom), 4'($urandom), 1'b0, 32'h0, cyc);
        end

        // independent channels active together on disjoint addresses
        fork
            do_write(8'd100, 4'd7, 4'd11, -1, 1'b0, resp);
            do_read(8'd1, 4'd5, 4'd12, 1'b0, 32'h0, cyc);
        join
        fork
            do_write(8'd250, 4'd9, 4'd13, -1, 1'b0, resp);
            do_read(8'd30, 4'd15, 4'd14, 1'b1, 32'hFFFF_FFFF, cyc2);
        join
        check("conc_bresp", 32'(resp), 32'd2);
        check("conc_rcycles", 32'(cyc2), 32'd16);

        // reset in the middle of a read and with a write address accepted
        bus.ARVALID = 1; bus.ARADDR = 8'd40; bus.ARLEN = 4'd7; bus.ARID = 4'd2;
        bus.AWVALID = 1; bus.AWADDR = 8'd70; bus.AWLEN = 4'd3; bus.AWID = 4'd8;
        @(negedge clk);
        bus.ARVALID = 0; bus.AWVALID = 0; bus.RREADY = 1;
        check("mid_rvalid", 32'(bus.RVALID), 32'd1);
        check("mid_wready", 32'(bus.WREADY), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.RREADY = 0;
        check("rstmid_rvalid", 32'(bus.RVALID), 32'd0);
        check("rstmid_arready", 32'(bus.ARREADY), 32'd1);
        check("rstmid_awready", 32'(bus.AWREADY), 32'd1);
        check("rstmid_wready", 32'(bus.WREADY), 32'd0);
        repeat (3) @(negedge clk);
        check("rstmid_no_b", 32'(bus.BVALID), 32'd0);
        check("rstmid_no_r", 32'(bus.RVALID), 32'd0);
        do_read(8'd48, 4'd3, 4'd1, 1'b0, 32'h0, cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
